// File: rtl/fir_movavg.sv
// fir_movavg: moving-average filter over a power-of-two window of unsigned samples.
// A running sum is kept exact by adding each new sample and subtracting the entry it
// overwrites. The mean is reported as an integer part plus an unrounded binary fraction.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   in_valid   in_data carries a new sample this cycle
//   in_data    unsigned sample, DW bits
//   clear      synchronous flush, same effect as rst; drops a coincident sample
//   out_valid  one-cycle pulse: avr_whole/avr_frac/sum_out carry a new result
//   avr_whole  integer part of the window mean
//   avr_frac   fractional part of the mean, units of 2^-FW
//   sum_out    sum of the last DEPTH accepted samples
//   filled     high while a full window has been collected (RUN state)
module fir_movavg #(
  parameter int unsigned DW         = 14,
  parameter int unsigned LOG2_DEPTH = 4,
  parameter int unsigned FW         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DW-1:0]              in_data,
  input  logic                       clear,
  output logic                       out_valid,
  output logic [DW-1:0]              avr_whole,
  output logic [FW-1:0]              avr_frac,
  output logic [DW+LOG2_DEPTH-1:0]   sum_out,
  output logic                       filled
);

  localparam int unsigned SW    = DW + LOG2_DEPTH;
  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned PW    = LOG2_DEPTH;
  localparam int unsigned SHIFT = FW - LOG2_DEPTH;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   cnt_q;
  logic [SW-1:0]   sum_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            out_valid_q;
  logic [DW-1:0]   avr_whole_q;
  logic [FW-1:0]   avr_frac_q;
  logic [SW-1:0]   sum_out_q;
  logic            filled_q;

  logic            accept_c;
  logic            last_fill_c;
  logic            out_hit_c;
  logic [DW-1:0]   oldest_c;
  logic [SW-1:0]   sum_d;
  logic [DW-1:0]   avr_whole_d;
  logic [FW-1:0]   avr_frac_d;

  // Datapath for the sample being accepted this cycle.
  always_comb begin
    accept_c    = in_valid & ~clear & ~rst;
    last_fill_c = (state_q == FILL) && (cnt_q == PW'(DEPTH - 1));
    out_hit_c   = accept_c && ((state_q == RUN) || last_fill_c);
    // In FILL the slot being written was never part of the window, so it counts as zero;
    // this is what lets the buffer itself go without a reset.
    oldest_c    = (state_q == RUN) ? mem_q[wr_ptr_q] : '0;
    sum_d       = sum_q + SW'(in_data) - SW'(oldest_c);
    avr_whole_d = sum_d[SW-1:LOG2_DEPTH];
    avr_frac_d  = FW'(sum_d[LOG2_DEPTH-1:0]) << SHIFT;
  end

  // Control state, running sum and registered outputs; rst and clear share one flush path.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      avr_whole_q <= '0;
      avr_frac_q  <= '0;
      sum_out_q   <= '0;
      filled_q    <= 1'b0;
    end else begin
      out_valid_q <= out_hit_c;
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        sum_q    <= sum_d;
        case (state_q)
          FILL: begin
            if (last_fill_c) begin
              state_q  <= RUN;
              filled_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + PW'(1);
            end
          end
          RUN: begin
            state_q <= RUN;
          end
          default: begin
            state_q <= FILL;
          end
        endcase
      end
      // Data outputs only move when a result is published; they hold otherwise.
      if (out_hit_c) begin
        sum_out_q   <= sum_d;
        avr_whole_q <= avr_whole_d;
        avr_frac_q  <= avr_frac_d;
      end
    end
  end

  // Sample storage; contents are masked by the FILL state, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign avr_whole = avr_whole_q;
  assign avr_frac  = avr_frac_q;
  assign sum_out   = sum_out_q;
  assign filled    = filled_q;

endmodule

// File: tb/tb_fir_movavg.sv
// tb_fir_movavg: directed and random stimulus for fir_movavg with a window-sum
// reference model and a scoreboard of expected results.
module tb_fir_movavg;

  localparam int unsigned DW         = 14;
  localparam int unsigned LOG2_DEPTH = 2;
  localparam int unsigned FW         = 16;
  localparam int unsigned SW         = DW + LOG2_DEPTH;
  localparam int          DEPTH      = 1 << LOG2_DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          clear;
  logic          out_valid;
  logic [DW-1:0] avr_whole;
  logic [FW-1:0] avr_frac;
  logic [SW-1:0] sum_out;
  logic          filled;

  fir_movavg #(.DW(DW), .LOG2_DEPTH(LOG2_DEPTH), .FW(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .avr_whole (avr_whole),
    .avr_frac  (avr_frac),
    .sum_out   (sum_out),
    .filled    (filled)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the literal window contents and the last published result.
  int win[$];
  int sb[$];
  int held_sum = 0;
  logic model_filled = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int win_sum();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s;
  endfunction

  // One clock: drive inputs, let the DUT take the edge, update the model, check outputs.
  task automatic cyc(input logic r, input logic c, input logic v, input int d);
    logic exp_valid;
    int   exp_sum;
    rst      = r;
    clear    = c;
    in_valid = v;
    in_data  = DW'(d);
    @(posedge clk);
    #1;
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    exp_valid = 1'b0;
    if (r || c) begin
      win.delete();
      sb.delete();
      held_sum     = 0;
      model_filled = 1'b0;
    end else if (v) begin
      win.push_back(d);
      if (win.size() > DEPTH) void'(win.pop_front());
      if (win.size() == DEPTH) begin
        model_filled = 1'b1;
        exp_valid    = 1'b1;
        sb.push_back(win_sum());
      end
    end
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("filled", 32'(filled), 32'(model_filled));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_sum  = sb.pop_front();
        held_sum = exp_sum;
      end
    end
    chk("sum_out", 32'(sum_out), 32'(held_sum));
    chk("avr_whole", 32'(avr_whole), 32'(held_sum >> LOG2_DEPTH));
    chk("avr_frac", 32'(avr_frac), 32'((held_sum & (DEPTH - 1)) << (FW - LOG2_DEPTH)));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);

    // Reset, then idle.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 0);
    chk("rst_sum_zero", 32'(sum_out), 32'd0);

    // First full window and one slide.
    cyc(1'b0, 1'b0, 1'b1, 100);
    cyc(1'b0, 1'b0, 1'b1, 200);
    cyc(1'b0, 1'b0, 1'b1, 300);
    cyc(1'b0, 1'b0, 1'b1, 400);
    chk("w1_sum", 32'(sum_out), 32'd1000);
    chk("w1_whole", 32'(avr_whole), 32'd250);
    chk("w1_frac", 32'(avr_frac), 32'd0);
    chk("w1_filled", 32'(filled), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 500);
    chk("w2_sum", 32'(sum_out), 32'd1400);
    chk("w2_whole", 32'(avr_whole), 32'd350);

    // Sparse samples with a fractional mean; outputs hold through the gaps.
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 1);
    cyc(1'b0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 2);
    chk("frac_sum", 32'(sum_out), 32'd5);
    chk("frac_whole", 32'(avr_whole), 32'd1);
    chk("frac_frac", 32'(avr_frac), 32'd16384);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 0);
    chk("frac_hold", 32'(sum_out), 32'd5);

    // Full-scale samples must not wrap the sum.
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 16383);
    chk("max_sum", 32'(sum_out), 32'd65532);
    chk("max_whole", 32'(avr_whole), 32'd16383);
    chk("max_frac", 32'(avr_frac), 32'd0);

    // Clear in RUN beats a coincident sample; a fresh window is required.
    cyc(1'b0, 1'b1, 1'b1, 999);
    chk("clr_sum", 32'(sum_out), 32'd0);
    chk("clr_filled", 32'(filled), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 10);
    cyc(1'b0, 1'b0, 1'b1, 20);
    cyc(1'b0, 1'b0, 1'b1, 30);
    cyc(1'b0, 1'b0, 1'b1, 43);
    chk("clr_new_sum", 32'(sum_out), 32'd103);
    chk("clr_new_frac", 32'(avr_frac), 32'd49152);

    // Reset and clear arriving mid-fill, plus reset over clear.
    cyc(1'b0, 1'b0, 1'b1, 7);
    cyc(1'b0, 1'b0, 1'b1, 8);
    cyc(1'b1, 1'b1, 1'b1, 9);
    cyc(1'b0, 1'b0, 1'b1, 11);
    cyc(1'b0, 1'b1, 1'b0, 0);
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 12);
    chk("refill_sum", 32'(sum_out), 32'd48);

    // Random traffic with sparse valid and rare clears.
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 16383)));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_movavg.md
FIR_MOVAVG -- requirements
Module: fir_movavg

Interface
REQ-001 Parameter DW, default 14: input sample width in bits (unsigned), legal 8..24.
REQ-002 Parameter LOG2_DEPTH, default 4: averaging window DEPTH = 2^LOG2_DEPTH samples, legal 1..8.
REQ-003 Parameter FW, default 16: fractional output width in bits, legal LOG2_DEPTH..24.
REQ-004 Derived SW = DW + LOG2_DEPTH: running-sum width.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 in_valid  input  1  in_data is a new sample this cycle.
REQ-008 in_data  input  DW  unsigned ADC sample.
REQ-009 clear  input  1  synchronous flush of the window and all outputs.
REQ-010 out_valid  output  1  one-cycle pulse: avr_whole, avr_frac and sum_out hold a new result.
REQ-011 avr_whole  output  DW  integer part of the window mean.
REQ-012 avr_frac  output  FW  fractional part of the window mean, in units of 2^-FW.
REQ-013 sum_out  output  SW  sum of the last DEPTH accepted samples.
REQ-014 filled  output  1  high once DEPTH samples have been accepted since the last reset or clear.

Function
REQ-015 The block SHALL accept a sample in every cycle with in_valid=1; it has no back-pressure and accepts one sample per cycle at full rate.
REQ-016 The block SHALL store accepted samples in a DEPTH-entry circular buffer; the write pointer SHALL advance by one per accepted sample and wrap from DEPTH-1 to 0.
REQ-017 The state machine SHALL have two states: FILL (reset state) and RUN.
REQ-018 In FILL, a count SHALL track accepted samples; the transition to RUN SHALL occur on the edge that accepts the DEPTH-th sample.
REQ-019 RUN SHALL persist until reset or clear.
REQ-020 On each accepted sample, the running sum SHALL update as sum + in_data - oldest, where oldest is the buffer entry being overwritten in RUN and zero in FILL.
REQ-021 Because of REQ-020, buffer contents SHALL never require reset.
REQ-022 Sum arithmetic SHALL be exact in SW bits; overflow is impossible by construction.
REQ-023 sum_out, avr_whole, avr_frac and out_valid SHALL be registered.
REQ-024 For a sample accepted in cycle t, the outputs SHALL be visible in cycle t+1 (latency 1).
REQ-025 avr_whole SHALL equal sum[SW-1:LOG2_DEPTH].
REQ-026 avr_frac SHALL equal sum[LOG2_DEPTH-1:0] shifted left by FW-LOG2_DEPTH bits, which gives an exact, unrounded mean.
REQ-027 out_valid SHALL pulse only for accepted samples that leave the block in RUN, including the DEPTH-th sample.
REQ-028 Data outputs SHALL hold their last value while out_valid is low.
REQ-029 filled SHALL be high exactly while the state is RUN.
REQ-030 Clear SHALL behave exactly like reset, and SHALL win over a simultaneous in_valid; that sample is dropped.
REQ-031 A clear in mid-window SHALL require DEPTH new samples before the next out_valid.

Reset
REQ-032 While rst=1 at a rising edge, the following SHALL go to 0: state=FILL, count, write pointer, running sum, out_valid, avr_whole, avr_frac, sum_out and filled.
REQ-033 rst SHALL take priority over clear and in_valid.
REQ-034 Reset asserted mid-operation SHALL discard the window, with the same result as REQ-031.

Verification (DW=14, LOG2_DEPTH=2, FW=16)
REQ-035 Reset release with idle inputs -> all outputs stay 0 and filled=0.
REQ-036 Samples 100, 200, 300, 400 on consecutive cycles -> out_valid stays low for the first three; after the 4th: out_valid=1, sum_out=1000, avr_whole=250, avr_frac=0, filled=1.
REQ-037 Next sample 500 -> sum_out=1400, avr_whole=350, avr_frac=0.
REQ-038 After reset, samples 1, 1, 1, 2 with idle gaps between them -> a single out_valid pulse after the 4th sample; sum_out=5, avr_whole=1, avr_frac=16384; outputs hold during the gaps.
REQ-039 Eight samples of 16383 -> sum_out=65532, avr_whole=16383, avr_frac=0; no wrap.
REQ-040 In RUN, clear=1 together with in_valid=1 -> next cycle all outputs=0, filled=0; the next out_valid occurs only after 4 further samples, with the mean of those 4 samples.
